// File: rtl/axi_pkg.sv
// Shared AXI write-side types: burst encodings, response codes and write FSM states.
// Also supplies default address/data widths when the build does not define them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    RESP = 2'b10
  } wr_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for AXI FIXED/INCR/WRAP bursts.
// Shared between write and read controllers; reserved bursts step like INCR.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [3:0]        len,
  input  burst_e            burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] w_bytes;
  logic [ADDR_W-1:0] w_wlen;
  logic [ADDR_W-1:0] w_lower;
  logic [ADDR_W-1:0] w_step;

  always_comb begin
    w_bytes = ADDR_W'(1) << size;
    w_wlen  = (ADDR_W'(len) + ADDR_W'(1)) * w_bytes;
    w_lower = addr & ~(w_wlen - ADDR_W'(1));
    w_step  = addr + w_bytes;
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = (w_step == w_lower + w_wlen) ? w_lower : w_step;
      default: next_addr = (addr & ~(w_bytes - ADDR_W'(1))) + w_bytes;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave_ctrl.sv
// AXI3 slave write controller: one burst at a time (AW, W beats, B), beats go straight to a memory port.
// Defining AXI_WR_PROTO_CHK_EN enables protocol checking that turns bresp into SLVERR.
//
// state | meaning
// IDLE  | awready high, waiting for a write address
// DATA  | accepting W beats, each written to memory in the same cycle
// RESP  | holding bvalid/bid/bresp until bready
module axi_wr_slave_ctrl
  import axi_pkg::*;
#(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic [3:0]        awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb
);

  wr_state_e         r_state, w_state_nxt;
  logic [3:0]        r_awid, r_len, r_cnt;
  logic [2:0]        r_size;
  burst_e            r_burst;
  logic [ADDR_W-1:0] r_addr, w_next_addr;
  logic              w_hs_aw, w_last_beat, w_err;

  assign w_hs_aw     = awvalid && awready;
  assign w_last_beat = wlast || (r_cnt == r_len);
  assign mem_we      = wvalid && wready;
  assign mem_addr    = r_addr;
  assign mem_wdata   = wdata;
  assign mem_wstrb   = wstrb;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (r_addr),
    .size      (r_size),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (w_next_addr)
  );

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    bid         = 4'd0;
    bresp       = OKAY;
    case (r_state)
      IDLE: begin
        awready = 1'b1;
        if (awvalid) w_state_nxt = DATA;
      end
      DATA: begin
        wready = 1'b1;
        if (wvalid && w_last_beat) w_state_nxt = RESP;
      end
      RESP: begin
        bvalid = 1'b1;
        bid    = r_awid;
        bresp  = w_err ? SLVERR : OKAY;
        if (bready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_addr always holds the address of the beat about to be accepted
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_awid  <= 4'd0;
      r_len   <= 4'd0;
      r_size  <= 3'd0;
      r_burst <= FIXED;
      r_addr  <= '0;
      r_cnt   <= 4'd0;
    end else if (w_hs_aw) begin
      r_awid  <= awid;
      r_len   <= awlen;
      r_size  <= awsize;
      r_burst <= burst_e'(awburst);
      r_addr  <= awaddr;
      r_cnt   <= 4'd0;
    end else if (mem_we) begin
      r_addr  <= w_next_addr;
      r_cnt   <= r_cnt + 4'd1;
    end
  end

`ifdef AXI_WR_PROTO_CHK_EN
  logic r_err, w_aw_err, w_beat_err;

  assign w_aw_err = (awburst == RSVD) || (awsize > 3'($clog2(STRB_W))) ||
                    ((awburst == WRAP) && !(awlen inside {4'd1, 4'd3, 4'd7, 4'd15}));
  assign w_beat_err = (wlast && (r_cnt < r_len)) || (!wlast && (r_cnt == r_len)) ||
                      (wid != r_awid);

  always_ff @(posedge aclk or posedge arst) begin
    if (arst)                    r_err <= 1'b0;
    else if (w_hs_aw)            r_err <= w_aw_err;
    else if (mem_we && w_beat_err) r_err <= 1'b1;
  end

  assign w_err = r_err;
`else
  logic w_unused_wid;

  assign w_unused_wid = ^wid;
  assign w_err        = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_slave_ctrl.sv
// Randomized self-checking bench for axi_wr_slave_ctrl against a burst-level model.
// Expected SLVERR behaviour follows AXI_WR_PROTO_CHK_EN when the build defines it.
module tb_axi_wr_slave_ctrl;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;
  beat_t exp_q[$];

`ifdef AXI_WR_PROTO_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  axi_wr_slave_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .arst(arst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Address rules in plain arithmetic: alignment by modulo, wrap window by modulo.
  function automatic logic [31:0] model_next(input logic [31:0] a, input int size,
                                             input int len, input int burst);
    longint unsigned b, wl, lo, nx;
    b = 64'd1 << size;
    if (burst == 0) return a;
    if (burst == 2) begin
      wl = longint'(len + 1) * b;
      lo = longint'(a) - (longint'(a) % wl);
      nx = longint'(a) + b;
      if (nx == lo + wl) nx = lo;
      return nx[31:0];
    end
    nx = longint'(a) - (longint'(a) % b) + b;
    return nx[31:0];
  endfunction

  function automatic bit model_aw_err(input int size, input int len, input int burst);
    return (burst == 3) || (size > 2) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  always @(negedge aclk) begin
    beat_t e;
    if (!arst && mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_mem_we", 64'(mem_we), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e.data));
        chk("mem_wstrb", 64'(mem_wstrb), 64'(e.strb));
      end
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst);
    int n;
    n = 0;
    @(posedge aclk); #1;
    awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    @(negedge aclk);
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) chk("aw_timeout", 64'(awready), 64'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] exp_addr, input logic last, input logic [3:0] id);
    beat_t e;
    int n;
    n = 0;
    wvalid = 1'b1; wdata = $urandom; wstrb = 4'($urandom); wlast = last; wid = id;
    e.addr = exp_addr; e.data = wdata; e.strb = wstrb;
    exp_q.push_back(e);
    @(negedge aclk);
    chk("awready_in_data", 64'(awready), 64'd0);
    while (!wready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) chk("w_timeout", 64'(wready), 64'd1);
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic recv_b(input logic [3:0] id, input logic [1:0] resp, input int hold);
    int n;
    n = 0;
    bready = 1'b0;
    @(negedge aclk);
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) chk("b_timeout", 64'(bvalid), 64'd1);
    for (int k = 0; k < hold; k++) begin
      chk("bvalid_hold", 64'(bvalid), 64'd1);
      chk("bid_hold", 64'(bid), 64'(id));
      chk("bresp_hold", 64'(bresp), 64'(resp));
      chk("awready_in_resp", 64'(awready), 64'd0);
      chk("wready_in_resp", 64'(wready), 64'd0);
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    bready = 1'b1;
    @(negedge aclk);
    chk("bvalid", 64'(bvalid), 64'd1);
    chk("bid", 64'(bid), 64'(id));
    chk("bresp", 64'(bresp), 64'(resp));
    @(posedge aclk); #1;
    bready = 1'b0;
    @(negedge aclk);
    chk("bvalid_after_b", 64'(bvalid), 64'd0);
    chk("awready_after_b", 64'(awready), 64'd1);
  endtask

  // last_at < 0 means wlast never asserted; bad_wid_at selects a beat carrying a wrong wid.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int last_at,
                           input int bad_wid_at, input int hold, input bit aw_noise);
    logic [31:0] a;
    logic [3:0]  w;
    bit err, last;
    int nb;
    send_aw(id, addr, len, size, burst);
    a = addr;
    err = model_aw_err(size, len, burst);
    nb = (last_at >= 0 && last_at <= len) ? last_at + 1 : len + 1;
    for (int i = 0; i < nb; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
      if (aw_noise) begin awvalid = 1'b1; awaddr = $urandom; end
      last = (i == last_at);
      w = (i == bad_wid_at) ? (id ^ 4'h1) : id;
      if ((last && i < len) || (!last && i == len) || (w != id)) err = 1'b1;
      send_beat(a, last, w);
      a = model_next(a, size, len, burst);
    end
    awvalid = 1'b0;
    recv_b(id, (CHK_EN && err) ? 2'b10 : 2'b00, hold);
  endtask

  initial begin
    int bu, sz, ln, la, bw, rr;
    logic [31:0] addr;
    int wrap_lens[4];
    wrap_lens = '{1, 3, 7, 15};

    chk("model_incr", 64'(model_next(32'h100, 2, 3, 1)), 64'h104);
    chk("model_unaligned", 64'(model_next(32'h103, 2, 1, 1)), 64'h104);
    chk("model_wrap_step", 64'(model_next(32'h38, 2, 3, 2)), 64'h3C);
    chk("model_wrap_back", 64'(model_next(32'h3C, 2, 3, 2)), 64'h30);
    chk("model_fixed", 64'(model_next(32'h200, 2, 2, 0)), 64'h200);
    chk("model_modulo", 64'(model_next(32'hFFFF_FFFC, 2, 1, 1)), 64'h0);

    wvalid = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_bid", 64'(bid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    arst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("idle_w_stall", 64'(wready), 64'd0);
    end
    @(posedge aclk); #1;
    wvalid = 1'b0;

    run_burst(4'hA, 32'h100, 3, 2, 1, 3, -1, 0, 1'b0);
    run_burst(4'h3, 32'h38, 3, 2, 2, 3, -1, 1, 1'b0);
    run_burst(4'h6, 32'h200, 2, 2, 0, 2, -1, 5, 1'b1);
    run_burst(4'h1, 32'h103, 1, 2, 1, 1, -1, 0, 1'b0);
    run_burst(4'h2, 32'h300, 3, 2, 1, 1, -1, 0, 1'b0);
    run_burst(4'h7, 32'h500, 3, 2, 1, 3, 2, 0, 1'b0);
    run_burst(4'h9, 32'h600, 2, 2, 1, -1, -1, 0, 1'b0);
    run_burst(4'hC, 32'h700, 1, 2, 3, 1, -1, 0, 1'b0);
    run_burst(4'hD, 32'h800, 1, 3, 1, 1, -1, 0, 1'b0);
    run_burst(4'hE, 32'hFFFF_FFFC, 1, 2, 1, 1, -1, 0, 1'b0);

    // reset while beat 2 of a 4-beat burst is on the bus
    send_aw(4'h5, 32'h400, 3, 2, 1);
    send_beat(32'h400, 1'b0, 4'h5);
    send_beat(32'h404, 1'b0, 4'h5);
    wvalid = 1'b1; wdata = $urandom; wlast = 1'b0;
    #2 arst = 1'b1;
    #1;
    chk("midrst_awready", 64'(awready), 64'd1);
    chk("midrst_wready", 64'(wready), 64'd0);
    chk("midrst_bvalid", 64'(bvalid), 64'd0);
    chk("midrst_bid", 64'(bid), 64'd0);
    chk("midrst_bresp", 64'(bresp), 64'd0);
    chk("midrst_mem_we", 64'(mem_we), 64'd0);
    wvalid = 1'b0;
    @(posedge aclk); #1;
    arst = 1'b0;
    bready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      chk("no_b_after_rst", 64'(bvalid), 64'd0);
    end
    bready = 1'b0;
    run_burst(4'hB, 32'h480, 3, 2, 1, 3, -1, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      bu = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      ln = $urandom_range(0, 15);
      if (bu == 2) ln = wrap_lens[$urandom_range(0, 3)];
      addr = 32'($urandom_range(0, 32'hFFFF));
      if (bu == 2) addr = addr & ~32'((1 << sz) - 1);
      la = ln;
      rr = $urandom_range(0, 9);
      if (rr == 0) la = -1;
      else if (rr == 1) la = $urandom_range(0, ln);
      bw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ln) : -1;
      run_burst(4'($urandom), addr, ln, sz, bu, la, bw, $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
